// File: rtl/fwrisc_muldiv.sv
// RV32M multiply/divide unit: shift-add multiply, restoring divide, one operation in flight.
// Latency: result valid 33 cycles after acceptance, 1 cycle for divide-by-zero and signed overflow.
// Backpressure: result held in DONE until out_ready; in_ready low from acceptance until result consumed.
module fwrisc_muldiv (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic        neg_q;
    logic [31:0] opnd_q;
    logic [63:0] acc_q;
    logic [5:0]  cnt_q;

    logic        is_div, a_signed, b_signed, sa, sb;
    logic        div_zero, div_ovf, special;
    logic [31:0] a_mag, b_mag, special_res;
    logic [32:0] mul_sum, div_sh, div_diff;
    logic [63:0] mul_nxt, div_nxt, acc_nxt;
    logic [31:0] hi_neg, lo_neg, result;

    // Operand decode on the request inputs
    assign is_div   = op[2];
    assign a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    assign b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    assign sa       = a_signed & op_a[31];
    assign sb       = b_signed & op_b[31];
    assign a_mag    = sa ? (~op_a + 32'd1) : op_a;
    assign b_mag    = sb ? (~op_b + 32'd1) : op_b;
    assign div_zero = is_div && (op_b == 32'd0);
    assign div_ovf  = is_div && !op[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    assign special  = div_zero || div_ovf;
    assign special_res = div_zero ? (op[1] ? op_a : 32'hFFFF_FFFF)
                                  : (op[1] ? 32'd0 : 32'h8000_0000);

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_nxt = {mul_sum, acc_q[31:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}
    assign div_sh   = acc_q[63:31];
    assign div_diff = div_sh - {1'b0, opnd_q};
    assign div_nxt  = div_diff[32] ? {div_sh[31:0], acc_q[30:0], 1'b0}
                                   : {div_diff[31:0], acc_q[30:0], 1'b1};
    assign acc_nxt  = op_q[2] ? div_nxt : mul_nxt;

    // Sign fix-up of the final iteration's value; the high half of a negated
    // 64-bit product only borrows from below when the low half is zero.
    always_comb begin
        hi_neg = ~acc_nxt[63:32] + {31'd0, (acc_nxt[31:0] == 32'd0)};
        lo_neg = ~acc_nxt[31:0] + 32'd1;
        result = acc_nxt[31:0];
        case (op_q)
            3'd0:       result = acc_nxt[31:0];
            3'd1, 3'd2,
            3'd3:       result = neg_q ? hi_neg : acc_nxt[63:32];
            3'd4, 3'd5: result = neg_q ? lo_neg : acc_nxt[31:0];
            default:    result = neg_q ? (~acc_nxt[63:32] + 32'd1) : acc_nxt[63:32];
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = special ? DONE : CALC;
            CALC:    if (cnt_q == 6'd1) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q   <= 3'd0;
            neg_q  <= 1'b0;
            opnd_q <= 32'd0;
            acc_q  <= 64'd0;
            cnt_q  <= 6'd0;
            out    <= 32'd0;
        end else if (state == IDLE && in_valid) begin
            op_q   <= op;
            // REM takes the dividend's sign; every other signed op takes the XOR
            neg_q  <= (is_div && op[1]) ? sa : (sa ^ sb);
            opnd_q <= is_div ? b_mag : a_mag;
            acc_q  <= {32'd0, is_div ? a_mag : b_mag};
            cnt_q  <= 6'd32;
            if (special) out <= special_res;
        end else if (state == CALC) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q - 6'd1;
            if (cnt_q == 6'd1) out <= result;
        end
    end
endmodule

// File: tb/tb_fwrisc_muldiv.sv
// Directed bench for fwrisc_muldiv with a cycle-level reference model and per-cycle output compare.
module tb_fwrisc_muldiv;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    fwrisc_muldiv dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        int              ia, ib, iq;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                iq = ia / ib; return iq;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                iq = ia % ib; return iq;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && b == 32'd0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Reference: 0 idle, 1 busy, 2 result pending; result shows up ref_lat edges
    // after acceptance counting the acceptance edge as the first.
    int          m_state = 0;
    int          m_left  = 0;
    logic [31:0] m_out   = 32'd0;
    logic [31:0] m_exp   = 32'd0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_state = 0;
            m_left  = 0;
            m_out   = 32'd0;
        end else begin
            case (m_state)
                0: if (in_valid) begin
                    m_exp  = ref_res(op, op_a, op_b);
                    m_left = ref_lat(op, op_a, op_b) - 1;
                    if (m_left == 0) begin m_state = 2; m_out = m_exp; end
                    else m_state = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin m_state = 2; m_out = m_exp; end
                end
                default: if (out_ready) m_state = 0;
            endcase
        end
    end

    always @(negedge clock) begin
        check("cmp_in_ready",  {31'd0, in_ready},  {31'd0, m_state == 0});
        check("cmp_out_valid", {31'd0, out_valid}, {31'd0, m_state == 2});
        check("cmp_out",       out, m_out);
    end

    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input int hold, input int poke);
        int n;
        @(negedge clock);
        in_valid = 1'b1; op = o; op_a = a; op_b = b;
        @(negedge clock);
        in_valid = 1'b0; op = 3'($urandom); op_a = $urandom; op_b = $urandom;
        n = 1;
        while (!out_valid && n < 100) begin
            @(negedge clock);
            n++;
            in_valid = (poke > 0) && (n >= poke) && (n < poke + 3);
        end
        in_valid = 1'b0;
        check("latency", 32'(n), 32'(lat));
        check("result", out, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check("hold_out", out, exp);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("retained_out", out, exp);
    endtask

    initial begin
        #400000;
        bad++;
        $display("FAIL watchdog expired");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out", out, 32'd0);
        reset = 1'b1;

        run(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0, 0);
        run(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, 0, 0);
        run(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0, 0);
        run(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0, 0);
        run(3'd1, 32'hFFFF_FFFD,  32'd5,         32'hFFFF_FFFF, 33, 0, 0);
        run(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, 0, 0);
        run(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, 0, 0);
        run(3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0, 0);
        run(3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         33, 0, 0);
        run(3'd5, 32'd100,        32'd7,         32'd14,        33, 0, 0);
        run(3'd7, 32'd100,        32'd7,         32'd2,         33, 0, 0);
        run(3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  0, 0);
        run(3'd7, 32'd5,          32'd0,         32'd5,         1,  0, 0);
        run(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  0, 0);
        run(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  0, 0);
        run(3'd5, 32'hFFFF_FFFF,  32'd16,        32'h0FFF_FFFF, 33, 10, 10);

        // Abort a DIVU part-way through with an asynchronous reset
        @(negedge clock);
        in_valid = 1'b1; op = 3'd5; op_a = 32'd1000; op_b = 32'd3;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (15) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        run(3'd0, 32'd3, 32'd4, 32'd12, 33, 0, 0);

        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fwrisc_muldiv.md
Name: fwrisc_muldiv

Overview:
- Iterative multi-cycle RV32M multiply/divide unit for fwrisc. It covers the arithmetic the single-cycle ALU does not.
- The exec stage issues one operation over a valid/ready request handshake. The unit computes over a fixed number of cycles and returns one 32-bit result over a valid/ready response handshake.
- One operation in flight at a time. No pipelining.

Parameters:
- none (data width fixed at 32; iteration count fixed at 32)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request
- op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- op_a  input  32  rs1 operand (dividend / multiplicand)
- op_b  input  32  rs2 operand (divisor / multiplier)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out  output  32  result

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, in_ready=1, out_valid=0, out=0, all internal registers cleared.
  - Reset asserted mid-operation aborts the operation. No result is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - Acceptance occurs on a rising edge with in_valid=1 (in_ready=1 implied). op, op_a and op_b are captured on that edge; later changes to the inputs are ignored.
  - Special cases go IDLE->DONE directly (result visible one cycle after acceptance):
    - DIV/DIVU with op_b=0: out=32'hFFFF_FFFF.
    - REM/REMU with op_b=0: out=op_a.
    - DIV with op_a=32'h8000_0000 and op_b=32'hFFFF_FFFF: out=32'h8000_0000.
    - REM with the same operands: out=0.
  - All other operations go IDLE->CALC. The 6-bit iteration counter is loaded with 32.
- CALC:
  - in_ready=0.
  - Exactly 32 iterations, one per clock. The counter decrements each cycle; the last iteration is the one with counter=1. CALC->DONE when the counter reaches 0.
  - Signed operands are converted to magnitudes on entry.
    - Signed operands: MULH both; MULHSU op_a only; DIV and REM both.
    - MUL is sign-agnostic (low 32 bits of the product are identical for any signedness).
  - Multiply: shift-add, 64-bit accumulator.
    - MUL returns product[31:0].
    - MULH/MULHSU/MULHU return product[63:32].
    - The negated 64-bit product is used when the result sign is negative, i.e. the XOR of the operand signs for signed-treated operands.
  - Divide: restoring, 32-bit partial remainder and quotient.
    - Quotient is negated when sign(op_a) XOR sign(op_b), DIV only.
    - Remainder takes the sign of op_a, REM only.
    - Unsigned variants apply no sign correction.
  - Sign fix-up is applied when writing out on the CALC->DONE transition.
- DONE:
  - out_valid=1 and out holds its value stable while out_valid=1.
  - DONE->IDLE on the edge where out_ready=1.
  - Latency: normal operations assert out_valid 33 cycles after the acceptance edge; special cases after 1 cycle. If out_ready is held at 1, the unit re-accepts no earlier than the cycle after the result is consumed (in_ready=0 in DONE).
  - out retains the last result after leaving DONE, until the next result is written.
- in_valid while busy is ignored and not queued. out_ready outside DONE has no effect.
- All arithmetic is modulo 2^32 on outputs. No exceptions or flags.

Test Plan:
- MUL op_a=7, op_b=32'hFFFF_FFFD (-3) -> out=32'hFFFF_FFEB (-21); out_valid exactly 33 cycles after acceptance; in_ready=0 throughout.
- MULH 32'h8000_0000 x 32'h8000_0000 -> 32'h4000_0000. MULHU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> 32'hFFFF_FFFE. MULHSU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> 32'hFFFF_FFFF.
- DIV -7/2 -> 32'hFFFF_FFFD; REM -7/2 -> 32'hFFFF_FFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 32'hFFFF_FFFF and REMU 5/0 -> 5, each one cycle after acceptance. DIV 32'h8000_0000/-1 -> 32'h8000_0000 and REM of the same -> 0, one cycle after acceptance.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid: out_valid and out stay stable, in_ready stays 0.
  - A new in_valid during CALC is ignored.
  - Raising out_ready returns the unit to IDLE next cycle with in_ready=1.
- Drive reset low at iteration 15 of a DIVU -> out_valid=0, in_ready=1 immediately (asynchronously). After release, a new MUL 3x4 returns 12 with normal latency.
